// File: rtl/pong_pkg.sv
// Shared types, default geometry and small helpers for the pong game controller.
package pong_pkg;

    // Game FSM states; the numeric values are visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    // Direction along one axis: positive is right on x and down on y.
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_e;

    // Default screen, ball, paddle and game-rule constants.
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_BALL_SIZE   = 4;
    localparam int DEF_PADDLE_W    = 5;
    localparam int DEF_PADDLE_H    = 50;
    localparam int DEF_STEP        = 1;
    localparam int DEF_WIN_SCORE   = 9;
    localparam int DEF_HOLD_FRAMES = 60;

    // Reverse a direction.
    function automatic dir_e flip_dir(input dir_e d);
        return (d == DIR_POS) ? DIR_NEG : DIR_POS;
    endfunction

    // Clamp a signed 11-bit coordinate onto [0, hi] so a step past an edge never wraps.
    function automatic logic [9:0] clamp_coord(input logic signed [10:0] v,
                                               input logic        [9:0]  hi);
        if (v < 11'sd0) begin
            return 10'd0;
        end
        if (v > $signed({1'b0, hi})) begin
            return hi;
        end
        return v[9:0];
    endfunction

endpackage

// File: rtl/pong_collide.sv
// Combinational ball motion and collision resolution for one game update:
// steps the ball, clamps it onto the screen, resolves paddle bounces and
// wall bounces, and flags a miss at either side.
module pong_collide
    import pong_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int STEP      = DEF_STEP
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  dir_e       dx_i,
    input  dir_e       dy_i,
    input  logic [9:0] p1_y_i,
    input  logic [9:0] p2_y_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output dir_e       dx_o,
    output dir_e       dy_o,
    output logic       miss_left_o,
    output logic       miss_right_o
);

    // Largest legal top-left corner on each axis.
    localparam logic [9:0] X_MAX = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - BALL_SIZE);

    // x positions where the ball rests against the left and right paddle faces.
    localparam logic [9:0] X_HIT_L = 10'(PADDLE_W);
    localparam logic [9:0] X_HIT_R = 10'(SCREEN_W - PADDLE_W - BALL_SIZE);

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic        [10:0] BALL_U  = 11'(BALL_SIZE);
    localparam logic        [10:0] PAD_H_U = 11'(PADDLE_H);

    logic signed [10:0] x_raw;
    logic signed [10:0] y_raw;
    logic        [9:0]  x_clamp;
    logic        [9:0]  y_clamp;
    logic               rows_left;
    logic               rows_right;

    // Raw next position at 11-bit signed width, then clamped onto the screen.
    always_comb begin
        x_raw = (dx_i == DIR_POS) ? ($signed({1'b0, x_i}) + STEP_S)
                                  : ($signed({1'b0, x_i}) - STEP_S);
        y_raw = (dy_i == DIR_POS) ? ($signed({1'b0, y_i}) + STEP_S)
                                  : ($signed({1'b0, y_i}) - STEP_S);
        x_clamp = clamp_coord(x_raw, X_MAX);
        y_clamp = clamp_coord(y_raw, Y_MAX);
    end

    // Vertical overlap of the ball (at its current row) with each paddle, in 11 bits
    // so a paddle near the bottom of the coordinate range cannot wrap.
    assign rows_left  = (({1'b0, y_i} + BALL_U) > {1'b0, p1_y_i}) &&
                        ({1'b0, y_i} < ({1'b0, p1_y_i} + PAD_H_U));
    assign rows_right = (({1'b0, y_i} + BALL_U) > {1'b0, p2_y_i}) &&
                        ({1'b0, y_i} < ({1'b0, p2_y_i} + PAD_H_U));

    // Paddle test decides x and dx first; the wall test on y is independent, so a
    // corner contact flips both directions in the same update.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
        x_o          = x_clamp;
        y_o          = y_clamp;
        dx_o         = dx_i;
        dy_o         = dy_i;
        miss_left_o  = 1'b0;
        miss_right_o = 1'b0;

        if (dx_i == DIR_NEG) begin
            if ((x_clamp <= X_HIT_L) && rows_left) begin
                x_o  = X_HIT_L;
                dx_o = DIR_POS;
            end else if (x_clamp == 10'd0) begin
                miss_left_o = 1'b1;
            end
        end else begin
            if ((x_clamp >= X_HIT_R) && rows_right) begin
                x_o  = X_HIT_R;
                dx_o = DIR_NEG;
            end else if (x_clamp == X_MAX) begin
                miss_right_o = 1'b1;
            end
        end

        if ((y_clamp == 10'd0) || (y_clamp == Y_MAX)) begin
            dy_o = flip_dir(dy_i);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: owns the game FSM, ball position and direction, the two
// scores and the post-point hold counter. All progress happens on frame_tick.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PADDLE_W    = DEF_PADDLE_W,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int STEP        = DEF_STEP,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] state,
    output logic       ball_en
);

    localparam logic [9:0] X_CENTRE = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTRE = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);

    // Hold counter counts 0 .. HOLD_FRAMES-1 while a point is being shown.
    localparam int              HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    state_e              state_q,   state_d;
    logic   [9:0]        ball_x_q,  ball_x_d;
    logic   [9:0]        ball_y_q,  ball_y_d;
    dir_e                dx_q,      dx_d;
    dir_e                dy_q,      dy_d;
    logic   [3:0]        score1_q,  score1_d;
    logic   [3:0]        score2_q,  score2_d;
    logic   [HOLD_W-1:0] hold_q,    hold_d;

    logic [9:0] col_x;
    logic [9:0] col_y;
    dir_e       col_dx;
    dir_e       col_dy;
    logic       col_miss_left;
    logic       col_miss_right;

    // Add one point, saturating at the winning score.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : (s + 4'd1);
    endfunction

    pong_collide #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H),
        .STEP      (STEP)
    ) u_collide (
        .x_i          (ball_x_q),
        .y_i          (ball_y_q),
        .dx_i         (dx_q),
        .dy_i         (dy_q),
        .p1_y_i       (p1_y),
        .p2_y_i       (p2_y),
        .x_o          (col_x),
        .y_o          (col_y),
        .dx_o         (col_dx),
        .dy_o         (col_dy),
        .miss_left_o  (col_miss_left),
        .miss_right_o (col_miss_right)
    );

    // Game state registers; reset recentres the ball and abandons any point in progress.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ball_x_q <= X_CENTRE;
            ball_y_q <= Y_CENTRE;
            dx_q     <= DIR_POS;
            dy_q     <= DIR_POS;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
            hold_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values from the always_comb block.
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state logic: everything holds unless frame_tick is high this cycle.
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        score1_d = score1_q;
        score2_d = score2_q;
        hold_d   = hold_q;

        if (frame_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    ball_x_d = X_CENTRE;
                    ball_y_d = Y_CENTRE;
                    if (serve) begin
                        state_d = ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    ball_x_d = col_x;
                    ball_y_d = col_y;
                    dx_d     = col_dx;
                    dy_d     = col_dy;
                    // The next serve heads toward whoever lost the point.
                    if (col_miss_left) begin
                        score2_d = sat_inc(score2_q);
                        dx_d     = DIR_NEG;
                        hold_d   = '0;
                        state_d  = ST_SCORED;
                    end else if (col_miss_right) begin
                        score1_d = sat_inc(score1_q);
                        dx_d     = DIR_POS;
                        hold_d   = '0;
                        state_d  = ST_SCORED;
                    end
                end

                ST_SCORED: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d   = '0;
                        ball_x_d = X_CENTRE;
                        ball_y_d = Y_CENTRE;
                        state_d  = ((score1_q == WIN) || (score2_q == WIN)) ? ST_OVER : ST_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end

                ST_OVER: begin
                    if (serve) begin
                        score1_d = 4'd0;
                        score2_d = 4'd0;
                        ball_x_d = X_CENTRE;
                        ball_y_d = Y_CENTRE;
                        state_d  = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs come straight from registers, so reset reaches them without a clock edge.
    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign score1  = score1_q;
    assign score2  = score2_q;
    assign state   = state_q;
    assign ball_en = (state_q == ST_IDLE) || (state_q == ST_PLAY);

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 Parameter BALL_SIZE, default 4, ball width and height.
REQ-004 Parameter PADDLE_W, default 5, paddle width; PADDLE_H, default 50, paddle height.
REQ-005 Parameter STEP, default 1, ball pixels moved per axis per update.
REQ-006 Parameters WIN_SCORE (default 9, points to win) and HOLD_FRAMES (default 60, post-score pause).
REQ-007 pixel_clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 frame_tick  in  1  one-cycle pulse per frame; the only event that advances the game.
REQ-010 serve  in  1  level; sampled only on frame_tick.
REQ-011 p1_y, p2_y  in  10 each  top row of the left and right paddles.
REQ-012 ball_x, ball_y  out  10 each  top-left corner of the ball.
REQ-013 score1, score2  out  4 each  player points.
REQ-014 state  out  2  encoded FSM state.
REQ-015 ball_en  out  1  high when the ball is drawn.

Function
REQ-016 FSM states SHALL be IDLE=0, PLAY=1, SCORED=2, OVER=3, updated only on cycles where frame_tick=1.
REQ-017 IDLE: ball at centre ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2); serve=1 -> PLAY.
REQ-018 Serve direction: dx right and dy down after reset; after a point, dx points toward the player who lost it; dy is unchanged.
REQ-019 PLAY: each tick moves the ball STEP per axis; outputs change on the edge after the one sampling frame_tick (1-cycle latency).
REQ-020 Next position SHALL be computed at 11-bit signed width and clamped to [0, SCREEN_W-BALL_SIZE] and [0, SCREEN_H-BALL_SIZE]; no 10-bit wrap.
REQ-021 Vertical wall: a clamped y of 0 or SCREEN_H-BALL_SIZE SHALL invert dy in the same update.
REQ-022 Left paddle hit: dx left, next x <= PADDLE_W, and ball_y+BALL_SIZE > p1_y and ball_y < p1_y+PADDLE_H -> x=PADDLE_W, dx right.
REQ-023 Right paddle hit: mirror of REQ-022 at x=SCREEN_W-PADDLE_W-BALL_SIZE, using p2_y.
REQ-024 Miss: dx left and next x reaches 0 without a hit -> score2+1, SCORED; right edge without a hit -> score1+1, SCORED.
REQ-025 Paddle checks SHALL have priority over wall checks; a corner case SHALL apply both the dx and the dy inversion in one update.
REQ-026 SCORED: ball_en=0; hold HOLD_FRAMES ticks, then OVER if any score == WIN_SCORE, else IDLE.
REQ-027 OVER: ball_en=0, scores frozen; serve=1 -> clear both scores, enter IDLE.
REQ-028 Scores SHALL saturate at WIN_SCORE.
REQ-029 ball_en SHALL be 1 in IDLE and PLAY.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, ball at centre, dx right, dy down, scores 0, hold counter 0, ball_en=1.
REQ-031 Reset asserted mid-PLAY or mid-SCORED SHALL abandon the point, with no score change.

Structure
REQ-032 A shared package pong_pkg SHALL hold the state enum, direction type, and screen/paddle/ball default constants.
REQ-033 Collision tests SHALL live in one sub-module, pong_collide: combinational, taking position, direction and paddle rows, returning next position, next direction and miss flags.

Verification
REQ-034 Reset, serve=1 on one tick -> state=PLAY, ball (318,238) moves to (319,239) one cycle after the next tick.
REQ-035 Ball at (6,100), dx left, p1_y=80, one tick -> ball_x=5, dx right, scores unchanged.
REQ-036 Ball at (1,300), dx left, p1_y=0 -> score2=1, state=SCORED, ball_en=0; after 60 ticks state=IDLE, next serve goes left.
REQ-037 Ball at y=475, dy down -> y=476, dy up; the next tick gives y=475.
REQ-038 score1=8, left player scores -> score1=9, OVER after the hold; serve -> scores 0, IDLE.
REQ-039 rst_n pulsed low mid-PLAY, between ticks -> all outputs equal reset values at once, not on the clock edge.
